// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between two cache controllers, the shared memory port and the arbiter.
// The arbiter uses the master modport; requesters and memory model use slave.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0, we0, ack0, err0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0, rdata0;
    logic          req1, we1, ack1, err1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1, rdata1;
    logic          mem_req, mem_we, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    modport master (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_ready, mem_rdata,
        output ack0, rdata0, err0, ack1, rdata1, err1, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_ready, mem_rdata,
        input  ack0, rdata0, err0, ack1, rdata1, err1, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache (0) and D-cache (1),
// holding the grant for a whole transaction and aborting stalled accesses on timeout.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.master    bus,
    output logic                  busy
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    localparam int             CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0]  CNT_MAX  = '1;

    state_t        state_q, state_d;
    logic          last_q, last_d, owner_q, owner_d, gnt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d, we_q, we_d, busy_q, busy_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [1:0]    ack_q, ack_d, err_q, err_d;

    // NOTE: every value written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        gnt      = 1'b0;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ack_d    = 2'b00;
        err_d    = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie the port that did not win last time goes first.
                    gnt     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    owner_d = gnt;
                    we_d    = gnt ? bus.we1    : bus.we0;
                    addr_d  = gnt ? bus.addr1  : bus.addr0;
                    wdata_d = gnt ? bus.wdata1 : bus.wdata0;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.mem_ready) begin
                    req_d          = 1'b0;
                    ack_d[owner_q] = 1'b1;
                    state_d        = S_RESP;
                    if (!we_q) begin
                        if (owner_q) rdata1_d = bus.mem_rdata;
                        else         rdata0_d = bus.mem_rdata;
                    end
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    req_d          = 1'b0;
                    ack_d[owner_q] = 1'b1;
                    err_d[owner_q] = 1'b1;
                    state_d        = S_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ack_q    <= 2'b00;
            err_q    <= 2'b00;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.ack0      = ack_q[0];
    assign bus.ack1      = ack_q[1];
    assign bus.err0      = err_q[0];
    assign bus.err1      = err_q[1];
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized transaction-level check of mem_port_arbiter against a round-robin reference model.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Per-port transaction description and reference model state.
    bit          p_req[2], p_we[2], pend[2], late[2];
    logic [31:0] p_addr[2], p_wdata[2], p_rd[2], exp_rdata[2];
    int          p_wait[2];
    bit          last_grant;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? bus.ack0 : bus.ack1;
    endfunction
    function automatic logic err_of(input int p);
        return (p == 0) ? bus.err0 : bus.err1;
    endfunction
    function automatic logic [DW-1:0] rdata_of(input int p);
        return (p == 0) ? bus.rdata0 : bus.rdata1;
    endfunction

    task automatic drive_port(input int p, input bit on);
        if (p == 0) begin
            bus.req0 = on; bus.we0 = p_we[0]; bus.addr0 = p_addr[0]; bus.wdata0 = p_wdata[0];
        end else begin
            bus.req1 = on; bus.we1 = p_we[1]; bus.addr1 = p_addr[1]; bus.wdata1 = p_wdata[1];
        end
    endtask

    // Serves all pending requests; gap is the expected number of cycles until mem_req.
    task automatic serve(input int first_gap);
        int gap, w, o, waited, hold;
        bit tmo;
        gap = first_gap;
        while (pend[0] || pend[1]) begin
            w = (pend[0] && pend[1]) ? int'(!last_grant) : (pend[0] ? 0 : 1);
            o = 1 - w;
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
                check("no_ack_while_waiting", {bus.ack0, bus.ack1}, 2'b00);
                bus.mem_ready = 1'($urandom_range(0, 1));
                bus.mem_rdata = $urandom;
            end while (!bus.mem_req && waited < 4);
            check("grant_latency", waited, gap);
            if (!bus.mem_req) begin
                pend[w] = 1'b0;
                drive_port(w, 1'b0);
                continue;
            end
            check("mem_we", bus.mem_we, p_we[w]);
            check("mem_addr", bus.mem_addr, p_addr[w]);
            check("mem_wdata", bus.mem_wdata, p_wdata[w]);
            check("busy_in_busy", busy, 1'b1);
            if (late[o]) begin
                late[o] = 1'b0;
                pend[o] = 1'b1;
                drive_port(o, 1'b1);
            end
            tmo  = (p_wait[w] > TO - 1);
            hold = tmo ? TO - 1 : p_wait[w];
            for (int k = 0; k <= hold; k++) begin
                if (k > 0) begin
                    @(negedge clk);
                    check("mem_req_held", bus.mem_req, 1'b1);
                    check("mem_addr_stable", bus.mem_addr, p_addr[w]);
                end
                bus.mem_ready = (k == p_wait[w]);
                bus.mem_rdata = (k == p_wait[w]) ? p_rd[w] : $urandom;
            end
            @(negedge clk);
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
            if (!p_we[w] && !tmo) exp_rdata[w] = p_rd[w];
            check("mem_req_released", bus.mem_req, 1'b0);
            check("ack_winner", ack_of(w), 1'b1);
            check("ack_other", ack_of(o), 1'b0);
            check("err_winner", err_of(w), tmo);
            check("rdata_winner", rdata_of(w), exp_rdata[w]);
            check("rdata_other", rdata_of(o), exp_rdata[o]);
            check("mem_addr_hold", bus.mem_addr, p_addr[w]);
            check("busy_in_resp", busy, 1'b1);
            last_grant = w[0];
            pend[w]    = 1'b0;
            drive_port(w, 1'b0);
            gap = 2;
        end
    endtask

    task automatic run_round();
        for (int p = 0; p < 2; p++) begin
            pend[p] = p_req[p];
            drive_port(p, p_req[p]);
        end
        serve(1);
        @(negedge clk);
        check("idle_ack", {bus.ack0, bus.ack1}, 2'b00);
        check("idle_busy", busy, 1'b0);
        check("idle_mem_req", bus.mem_req, 1'b0);
        bus.mem_ready = 1'b0;
    endtask

    task automatic set_port(input int p, input bit rq, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int wt, input logic [31:0] rd);
        p_req[p] = rq; p_we[p] = we; p_addr[p] = addr; p_wdata[p] = wdata;
        p_wait[p] = wt; p_rd[p] = rd; late[p] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
        bus.mem_ready = 0; bus.mem_rdata = '0;
        last_grant = 1'b1;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        pend[0] = 0; pend[1] = 0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_acks", {bus.ack0, bus.ack1, bus.err0, bus.err1}, 4'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rdata0", bus.rdata0, '0);
        check("rst_rdata1", bus.rdata1, '0);
        check("rst_mem_bus", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, '0);
        rst = 1'b1;

        // Tie after reset: port 0 first, then 1; repeated tie alternates again.
        set_port(0, 1, 0, 32'h100, 32'h0, 1, 32'hA0A0A0A0);
        set_port(1, 1, 0, 32'h200, 32'h0, 0, 32'hB1B1B1B1);
        run_round();
        run_round();
        // Single read with two wait cycles.
        set_port(0, 1, 0, 32'h40, 32'h0, 2, 32'hDEADBEEF);
        set_port(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        run_round();
        // Write-back on port 1 leaves rdata1 unchanged.
        set_port(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        set_port(1, 1, 1, 32'h1C, 32'h12345678, 1, 32'hCAFEF00D);
        run_round();
        // Timeout on port 0 with port 1 waiting behind it.
        set_port(0, 1, 0, 32'h80, 32'h0, 100, 32'h11111111);
        set_port(1, 1, 0, 32'h84, 32'h0, 0, 32'h22222222);
        run_round();
        // mem_ready exactly on the timeout cycle completes normally.
        set_port(0, 1, 0, 32'h88, 32'h0, TO - 1, 32'h33333333);
        set_port(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        run_round();

        for (int r = 0; r < 200; r++) begin
            for (int p = 0; p < 2; p++)
                set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                         $urandom_range(0, 6), $urandom);
            if (!p_req[0] && !p_req[1]) p_req[$urandom_range(0, 1)] = 1'b1;
            if (p_req[0] != p_req[1] && $urandom_range(0, 2) == 0) late[p_req[0] ? 1 : 0] = 1'b1;
            run_round();
        end

        // Asynchronous reset in the middle of a transaction.
        set_port(0, 1, 0, 32'hF0, 32'h0, 100, 32'h44444444);
        set_port(1, 0, 0, 32'hF4, 32'h0, 0, 32'h55555555);
        drive_port(0, 1'b1);
        @(negedge clk);
        check("pre_rst_mem_req", bus.mem_req, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_mem_req", bus.mem_req, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_ack", {bus.ack0, bus.ack1}, 2'b00);
        @(negedge clk);
        check("async_rst_rdata1", bus.rdata1, '0);
        last_grant = 1'b1;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        p_wait[0] = 1;
        p_req[1] = 1'b1;
        drive_port(1, 1'b1);
        pend[0] = 1'b1; pend[1] = 1'b1;
        rst = 1'b1;
        serve(1);
        @(negedge clk);
        check("final_idle_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
